// File: rtl/pe_grid_pkg.sv
// Shared constants, element/vector types and sequencer states for the PE grid pass controller.
// The optional stall counter of pe_grid_sequencer is enabled by the PE_SEQ_STALL_CNT_EN macro.
package pe_grid_pkg;

   localparam int ROWS      = 12;
   localparam int COLS      = 14;
   localparam int DW        = 16;
   localparam int PW        = 32;
   localparam int DRAIN_CYC = 12;
   localparam int CNT_W     = 16;
   localparam int TAG_W     = 4;
   localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

   typedef logic [DW-1:0] elem_t;
   typedef elem_t vec_t [COLS];
   typedef logic [PW-1:0] psum_t;
   typedef psum_t psum_vec_t [COLS];

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } seq_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pe_grid_sequencer_if.sv
// Buffer-side streams and grid injection/psum signals of the PE grid sequencer.
// A beat transfers on a rising edge where valid and ready are both high; ready never depends on valid.
interface pe_grid_sequencer_if;
   import pe_grid_pkg::*;

   vec_t             w_data;
   logic             w_valid;
   logic             w_ready;
   vec_t             x_data;
   logic             x_valid;
   logic             x_ready;
   vec_t             row_weight_vals;
   logic [TAG_W-1:0] tag_row;
   logic             valid_y;
   vec_t             image_val_vec;
   logic [COLS-1:0]  valid_x_vec;
   psum_vec_t        psum_ins;
   logic             psum_vld;

   modport master (
      input  w_data, w_valid, x_data, x_valid,
      output w_ready, x_ready, row_weight_vals, tag_row, valid_y,
             image_val_vec, valid_x_vec, psum_ins, psum_vld
   );

   modport slave (
      output w_data, w_valid, x_data, x_valid,
      input  w_ready, x_ready, row_weight_vals, tag_row, valid_y,
             image_val_vec, valid_x_vec, psum_ins, psum_vld
   );

endinterface

// File: rtl/pe_seq_delay_line.sv
// Fixed-depth 1-bit shift register with asynchronous active-low clear; models grid latency for psum_vld.
module pe_seq_delay_line #(
   parameter int DEPTH = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr <= '0;
      end else begin
         sr <= {sr[DEPTH-2:0], din};
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pe_grid_sequencer.sv
// Sequences one PE grid pass: weight row loads, image vector streaming, then psum drain and done.
// Defining PE_SEQ_STALL_CNT_EN adds a saturating stall_cnt output counting input-starved cycles.
module pe_grid_sequencer
   import pe_grid_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CNT_W-1:0]   cfg_num_pix,
   output logic               busy,
   output logic               done,
   output seq_state_e         dbg_state,
   pe_grid_sequencer_if.master sif
`ifdef PE_SEQ_STALL_CNT_EN
   ,output logic [31:0]       stall_cnt
`endif
);

   seq_state_e         state, state_next;
   logic [CNT_W-1:0]   num_pix;
   logic [CNT_W-1:0]   pix_cnt;
   logic [TAG_W-1:0]   row_cnt;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               start_acc;
   logic               w_beat;
   logic               x_beat;
   logic               last_row;
   logic               last_pix;
   logic               drain_end;
   logic               done_next;

   assign start_acc = (state == IDLE) && start;
   assign w_beat    = sif.w_valid && (state == LOAD_W);
   assign x_beat    = sif.x_valid && (state == STREAM);
   assign last_row  = (row_cnt == TAG_W'(ROWS - 1));
   assign last_pix  = (pix_cnt == num_pix - CNT_W'(1));
   assign drain_end = (drain_cnt == DRAIN_W'(DRAIN_CYC));

   assign sif.w_ready = (state == LOAD_W);
   assign sif.x_ready = (state == STREAM);
   assign busy        = (state != IDLE);
   assign dbg_state   = state;

   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         sif.psum_ins[c] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = LOAD_W;
         end
         LOAD_W: begin
            if (sif.w_valid && last_row) begin
               if (num_pix == '0) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = STREAM;
               end
            end
         end
         STREAM: begin
            if (sif.x_valid && last_pix) state_next = DRAIN;
         end
         DRAIN: begin
            // drain_cnt reaches DRAIN_CYC on the cycle the last psum_vld is out
            if (drain_end) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         num_pix             <= '0;
         pix_cnt             <= '0;
         row_cnt             <= '0;
         drain_cnt           <= '0;
         done                <= 1'b0;
         sif.valid_y         <= 1'b0;
         sif.tag_row         <= '0;
         sif.valid_x_vec     <= '0;
         sif.row_weight_vals <= '{default: '0};
         sif.image_val_vec   <= '{default: '0};
      end else begin
         done            <= done_next;
         sif.valid_y     <= w_beat;
         sif.valid_x_vec <= {COLS{x_beat}};
         if (start_acc) begin
            num_pix <= cfg_num_pix;
            row_cnt <= '0;
            pix_cnt <= '0;
         end
         if (w_beat) begin
            sif.row_weight_vals <= sif.w_data;
            sif.tag_row         <= row_cnt;
            if (!last_row) row_cnt <= row_cnt + TAG_W'(1);
         end
         if (x_beat) begin
            sif.image_val_vec <= sif.x_data;
            pix_cnt           <= pix_cnt + CNT_W'(1);
         end
         if ((state == DRAIN) && !drain_end) begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
         end else begin
            drain_cnt <= '0;
         end
      end
   end

   pe_seq_delay_line #(
      .DEPTH (DRAIN_CYC)
   ) u_psum_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (sif.valid_x_vec[0]),
      .dout (sif.psum_vld)
   );

`ifdef PE_SEQ_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (start_acc) begin
         stall_cnt <= '0;
      end else if (((state == LOAD_W) && !sif.w_valid) ||
                   ((state == STREAM) && !sif.x_valid)) begin
         stall_cnt <= sat_inc32(stall_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_pe_grid_sequencer.sv
// Directed bench for pe_grid_sequencer: full passes, handshake gaps, empty pass, ignored starts and async reset.
module tb_pe_grid_sequencer;
   import pe_grid_pkg::*;

   logic             clk;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] cfg_num_pix;
   logic             busy;
   logic             done;
   seq_state_e       dbg_state;
`ifdef PE_SEQ_STALL_CNT_EN
   logic [31:0]      stall_cnt;
`endif

   pe_grid_sequencer_if sif ();

   pe_grid_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cfg_num_pix (cfg_num_pix),
      .busy        (busy),
      .done        (done),
      .dbg_state   (dbg_state),
      .sif         (sif)
`ifdef PE_SEQ_STALL_CNT_EN
      ,.stall_cnt  (stall_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor logs, sampled on the falling edge
   int    cyc = 0;
   logic  bw_prev = 1'b0;
   logic  bx_prev = 1'b0;
   elem_t mon_e;
   logic [DW-1:0] exp_w_q[$];
   logic [DW-1:0] exp_x_q[$];
   int    tag_q[$];
   int    y_cyc_q[$];
   int    x_cyc_q[$];
   int    p_cyc_q[$];
   int    done_cnt, done_cyc, xr_cnt, gap_err, data_err, vec_err;

   always @(negedge clk) begin
      if (!rst) begin
         bw_prev = 1'b0;
         bx_prev = 1'b0;
      end else begin
         cyc++;
         if (sif.valid_y) begin
            tag_q.push_back(int'(sif.tag_row));
            y_cyc_q.push_back(cyc);
            if (!bw_prev) gap_err++;
            if (exp_w_q.size() == 0) data_err++;
            else begin
               mon_e = exp_w_q.pop_front();
               for (int c = 0; c < COLS; c++)
                  if (sif.row_weight_vals[c] !== mon_e + elem_t'(c)) data_err++;
            end
         end else if (bw_prev) gap_err++;
         if ((sif.valid_x_vec !== '0) && (sif.valid_x_vec !== '1)) vec_err++;
         if (sif.valid_x_vec[0]) begin
            x_cyc_q.push_back(cyc);
            if (!bx_prev) gap_err++;
            if (exp_x_q.size() == 0) data_err++;
            else begin
               mon_e = exp_x_q.pop_front();
               for (int c = 0; c < COLS; c++)
                  if (sif.image_val_vec[c] !== mon_e + elem_t'(c)) data_err++;
            end
         end else if (bx_prev) gap_err++;
         if (sif.psum_vld) p_cyc_q.push_back(cyc);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (sif.x_ready) xr_cnt++;
         bw_prev = sif.w_valid && sif.w_ready;
         bx_prev = sif.x_valid && sif.x_ready;
         if (bw_prev) exp_w_q.push_back(sif.w_data[0]);
         if (bx_prev) exp_x_q.push_back(sif.x_data[0]);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      exp_w_q.delete(); exp_x_q.delete();
      tag_q.delete(); y_cyc_q.delete(); x_cyc_q.delete(); p_cyc_q.delete();
      done_cnt = 0; done_cyc = 0; xr_cnt = 0; gap_err = 0; data_err = 0; vec_err = 0;
   endtask

   task automatic set_data(input int ph);
      for (int c = 0; c < COLS; c++) begin
         sif.w_data[c] = elem_t'(ph * 16 + c);
         sif.x_data[c] = elem_t'(ph * 16 + c + 32'h8000);
      end
   endtask

   // Called at posedge+1; returns on the done cycle or after the cycle budget.
   task automatic run_pass(input int n, input bit w_tog, input int x_gap, input bit poke);
      int npsum;
      bit seen_x, fin;
      clear_logs();
      cfg_num_pix = CNT_W'(n);
      start = 1'b1;
      @(posedge clk); #1;
      npsum = 0; seen_x = 1'b0; fin = 1'b0;
      for (int ph = 0; ph < 600 && !fin; ph++) begin
         start = 1'b0;
         if (sif.psum_vld) npsum++;
         if (done) fin = 1'b1;
         sif.w_valid = w_tog ? (ph % 2 == 0) : 1'b1;
         sif.x_valid = (ph % (x_gap + 1)) == 0;
         set_data(ph);
         if (poke && sif.x_ready && !seen_x) begin
            start = 1'b1; cfg_num_pix = 9; seen_x = 1'b1;
         end
         if (poke && sif.psum_vld && npsum == n) begin
            start = 1'b1; cfg_num_pix = 7;
         end
         if (!fin) begin
            @(posedge clk); #1;
         end
      end
      check("pass_finished", 32'(fin), 32'd1);
      start = 1'b0; sif.w_valid = 1'b0; sif.x_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_loads(input int span);
      check("load_count", 32'(tag_q.size()), 32'(ROWS));
      for (int i = 0; i < tag_q.size(); i++) check("tag_order", 32'(tag_q[i]), 32'(i));
      if (y_cyc_q.size() == ROWS)
         check("load_span", 32'(y_cyc_q[ROWS-1] - y_cyc_q[0]), 32'(span));
   endtask

   task automatic check_stream(input int n, input int period);
      check("strobe_count", 32'(x_cyc_q.size()), 32'(n));
      check("psum_count", 32'(p_cyc_q.size()), 32'(n));
      check("done_count", 32'(done_cnt), 32'd1);
      if (x_cyc_q.size() == n && p_cyc_q.size() == n && n > 0) begin
         for (int i = 0; i < n; i++)
            check("psum_delay", 32'(p_cyc_q[i] - x_cyc_q[i]), 32'(DRAIN_CYC));
         for (int i = 1; i < n; i++)
            check("strobe_period", 32'(x_cyc_q[i] - x_cyc_q[i-1]), 32'(period));
         check("done_after_psum", 32'(done_cyc - p_cyc_q[n-1]), 32'd1);
      end
      check("gap_errors", 32'(gap_err), 32'd0);
      check("data_errors", 32'(data_err), 32'd0);
      check("vec_errors", 32'(vec_err), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 1'b0; cfg_num_pix = '0;
      sif.w_valid = 1'b0; sif.x_valid = 1'b0;
      set_data(0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid_y", 32'(sif.valid_y), 32'd0);
      check("rst_tag_row", 32'(sif.tag_row), 32'd0);
      check("rst_valid_x", 32'(sif.valid_x_vec), 32'd0);
      check("rst_psum_vld", 32'(sif.psum_vld), 32'd0);
      check("rst_w_ready", 32'(sif.w_ready), 32'd0);
      check("rst_x_ready", 32'(sif.x_ready), 32'd0);
      check("rst_psum_ins", sif.psum_ins[COLS-1], 32'd0);
      check("rst_row_vals", 32'(sif.row_weight_vals[0]), 32'd0);
      @(posedge clk); #3;
      rst = 1'b1;
      @(posedge clk); #1;

      // Pass 1: four pixels, buffers always valid
      run_pass(4, 1'b0, 0, 1'b0);
      check_loads(ROWS - 1);
      check_stream(4, 1);
      check("p1_psum_ins", sif.psum_ins[0], 32'd0);
`ifdef PE_SEQ_STALL_CNT_EN
      check("p1_stall_cnt", stall_cnt, 32'd0);
`endif

      // Pass 2: weight valid toggling every cycle
      run_pass(2, 1'b1, 0, 1'b0);
      check_loads(2 * (ROWS - 1));
      check_stream(2, 1);
`ifdef PE_SEQ_STALL_CNT_EN
      check("p2_stall_cnt", stall_cnt, 32'd11);
`endif

      // Pass 3: image valid with 3-cycle gaps
      run_pass(5, 1'b0, 3, 1'b0);
      check_loads(ROWS - 1);
      check_stream(5, 4);

      // Pass 4: zero pixels ends right after the weight loads
      run_pass(0, 1'b0, 0, 1'b0);
      check_loads(ROWS - 1);
      check("p4_done_count", 32'(done_cnt), 32'd1);
      check("p4_x_ready", 32'(xr_cnt), 32'd0);
      check("p4_psum_count", 32'(p_cyc_q.size()), 32'd0);
      check("p4_strobe_count", 32'(x_cyc_q.size()), 32'd0);
      if (y_cyc_q.size() == ROWS)
         check("p4_done_cycle", 32'(done_cyc - y_cyc_q[ROWS-1]), 32'd0);

      // Pass 5: start pulses during STREAM and on the last DRAIN cycle
      run_pass(3, 1'b0, 0, 1'b1);
      check_loads(ROWS - 1);
      check_stream(3, 1);
      check("p5_state_idle", 32'(dbg_state), 32'(IDLE));

      // Pass 6: reset asserted while streaming
      clear_logs();
      cfg_num_pix = 20;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      sif.w_valid = 1'b1; sif.x_valid = 1'b1;
      for (int k = 0; k < 100 && !sif.x_ready; k++) begin
         @(posedge clk); #1;
      end
      check("p6_reached_stream", 32'(dbg_state), 32'(STREAM));
      repeat (3) @(posedge clk);
      #3;
      check("p6_pre_valid_x", 32'(sif.valid_x_vec), 32'h3fff);
      rst = 1'b0;
      #1;
      check("p6_rst_state", 32'(dbg_state), 32'(IDLE));
      check("p6_rst_busy", 32'(busy), 32'd0);
      check("p6_rst_valid_x", 32'(sif.valid_x_vec), 32'd0);
      check("p6_rst_image", 32'(sif.image_val_vec[0]), 32'd0);
      check("p6_rst_x_ready", 32'(sif.x_ready), 32'd0);
      check("p6_rst_psum_vld", 32'(sif.psum_vld), 32'd0);
      sif.w_valid = 1'b0; sif.x_valid = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("p6_no_done", 32'(done_cnt), 32'd0);
      check("p6_idle_after", 32'(busy), 32'd0);
      run_pass(3, 1'b0, 0, 1'b0);
      check_loads(ROWS - 1);
      check_stream(3, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
